fetch_stage: RTL and testbench

Instruction-fetch stage of the RISC-V core. It owns the program counter, drives the word address into the combinational instruction ROM, and captures the returned instruction word into the IF/ID pipeline register consumed by the decoder. It supports stall from hazard logic, redirect and flush from branch/jump resolution, and keeps a retired-fetch counter for debug.

---
 rtl/fetch_stage.sv | 95 +++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the RISC-V core.
// Owns the PC, addresses the combinational instruction ROM and captures the
// returned word into the IF/ID register. Supports stall, redirect/flush and a
// retired-fetch counter.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (sticky misaligned-redirect flag).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] fetch_count_o,
  output logic        misalign_err_o
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  assign pc_plus4       = pc + 32'd4;
  assign target_aligned = {redirect_target_i[31:2], 2'b00};
  assign imem_addr_o    = pc;

  // PC, IF/ID register, fetch counter and boot/run sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      ifid_valid_o  <= 1'b0;
      ifid_instr_o  <= NOP_INSTR;
      ifid_pc_o     <= '0;
      ifid_pc4_o    <= '0;
      fetch_count_o <= '0;
    end else begin
      case (state)
        // First edge after reset release always captures the RESET_PC fetch
        BOOT: begin
          state         <= RUN;
          ifid_valid_o  <= 1'b1;
          ifid_instr_o  <= imem_rdata_i;
          ifid_pc_o     <= pc;
          ifid_pc4_o    <= pc_plus4;
          pc            <= pc_plus4;
          fetch_count_o <= fetch_count_o + 32'd1;
        end
        default: begin
          state <= RUN;
          if (redirect_i) begin
            pc           <= target_aligned;
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= NOP_INSTR;
            ifid_pc_o    <= '0;
            ifid_pc4_o   <= '0;
          end else if (!stall_i) begin
            ifid_valid_o  <= 1'b1;
            ifid_instr_o  <= imem_rdata_i;
            ifid_pc_o     <= pc;
            ifid_pc4_o    <= pc_plus4;
            pc            <= pc_plus4;
            fetch_count_o <= fetch_count_o + 32'd1;
          end
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky flag: set by any taken redirect whose target is not word aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err_o <= 1'b0;
    end else if (state == RUN && redirect_i && (redirect_target_i[1:0] != 2'b00)) begin
      misalign_err_o <= 1'b1;
    end
  end
`else
  // Low target bits are dropped silently; no flag storage
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_target_i[1:0];
  assign misalign_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table applied through a
// scoreboard queue, plus a hand-written asynchronous-reset sequence.
module tb_fetch_stage;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] fetch_count_o;
  logic        misalign_err_o;

  logic [31:0] rom [128];

  int unsigned passed;
  int unsigned total;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_target_i(redirect_target_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .ifid_valid_o     (ifid_valid_o),
    .ifid_instr_o     (ifid_instr_o),
    .ifid_pc_o        (ifid_pc_o),
    .ifid_pc4_o       (ifid_pc4_o),
    .fetch_count_o    (fetch_count_o),
    .misalign_err_o   (misalign_err_o)
  );

  // Combinational ROM using address bits [8:2]
  assign imem_rdata_i = rom[imem_addr_o[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] target;
    exp_t        exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic s, logic r, logic [31:0] t, logic [31:0] a, logic v,
                              logic [31:0] i, logic [31:0] p, logic [31:0] p4,
                              logic [31:0] c, logic e);
    vec_t x;
    x.stall = s; x.redir = r; x.target = t;
    x.exp.addr = a; x.exp.valid = v; x.exp.instr = i; x.exp.pc = p;
    x.exp.pc4 = p4; x.exp.cnt = c; x.exp.err = e & MIS_EN;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, " addr"},  imem_addr_o,            e.addr);
    chk({tag, " valid"}, {31'd0, ifid_valid_o},  {31'd0, e.valid});
    chk({tag, " instr"}, ifid_instr_o,           e.instr);
    chk({tag, " pc"},    ifid_pc_o,              e.pc);
    chk({tag, " pc4"},   ifid_pc4_o,             e.pc4);
    chk({tag, " count"}, fetch_count_o,          e.cnt);
    chk({tag, " err"},   {31'd0, misalign_err_o}, {31'd0, e.err});
  endtask

  initial begin
    exp_t e;
    passed = 0;
    total  = 0;

    for (int unsigned k = 0; k < 128; k++) rom[k] = 32'h1000_0000 + k;
    rom[0] = 32'h0000_0493;
    rom[1] = 32'h0000_0413;
    rom[2] = 32'h00A0_0293;
    rom[3] = 32'h4054_0333;
    rom[4] = 32'h0003_23B3;

    //               stall redir target        addr          v instr         pc            pc4           cnt err
    vecs.push_back(mk(0, 0, 32'h0,        32'h04,       1, 32'h00000493, 32'h00,       32'h04,       1,  0));
    vecs.push_back(mk(0, 0, 32'h0,        32'h08,       1, 32'h00000413, 32'h04,       32'h08,       2,  0));
    vecs.push_back(mk(0, 0, 32'h0,        32'h0C,       1, 32'h00A00293, 32'h08,       32'h0C,       3,  0));
    vecs.push_back(mk(0, 0, 32'h0,        32'h10,       1, 32'h40540333, 32'h0C,       32'h10,       4,  0));
    vecs.push_back(mk(0, 0, 32'h0,        32'h14,       1, 32'h000323B3, 32'h10,       32'h14,       5,  0));
    vecs.push_back(mk(0, 0, 32'h0,        32'h18,       1, 32'h10000005, 32'h14,       32'h18,       6,  0));
    vecs.push_back(mk(0, 0, 32'h0,        32'h1C,       1, 32'h10000006, 32'h18,       32'h1C,       7,  0));
    vecs.push_back(mk(0, 0, 32'h0,        32'h20,       1, 32'h10000007, 32'h1C,       32'h20,       8,  0));
    vecs.push_back(mk(0, 0, 32'h0,        32'h24,       1, 32'h10000008, 32'h20,       32'h24,       9,  0));
    // jal back to 0x0C: one bubble, then the target
    vecs.push_back(mk(0, 1, 32'h0C,       32'h0C,       0, 32'h00000013, 32'h0,        32'h0,        9,  0));
    vecs.push_back(mk(0, 0, 32'h0,        32'h10,       1, 32'h40540333, 32'h0C,       32'h10,       10, 0));
    // three-cycle stall at pc=0x10, then release
    vecs.push_back(mk(1, 0, 32'h0,        32'h10,       1, 32'h40540333, 32'h0C,       32'h10,       10, 0));
    vecs.push_back(mk(1, 0, 32'h0,        32'h10,       1, 32'h40540333, 32'h0C,       32'h10,       10, 0));
    vecs.push_back(mk(1, 0, 32'h0,        32'h10,       1, 32'h40540333, 32'h0C,       32'h10,       10, 0));
    vecs.push_back(mk(0, 0, 32'h0,        32'h14,       1, 32'h000323B3, 32'h10,       32'h14,       11, 0));
    // redirect beats a simultaneous stall
    vecs.push_back(mk(1, 1, 32'h18,       32'h18,       0, 32'h00000013, 32'h0,        32'h0,        11, 0));
    vecs.push_back(mk(0, 0, 32'h0,        32'h1C,       1, 32'h10000006, 32'h18,       32'h1C,       12, 0));
    // misaligned target: low bits dropped, flag sticky when enabled
    vecs.push_back(mk(0, 1, 32'h1A,       32'h18,       0, 32'h00000013, 32'h0,        32'h0,        12, 1));
    vecs.push_back(mk(0, 0, 32'h0,        32'h1C,       1, 32'h10000006, 32'h18,       32'h1C,       13, 1));
    // pc+4 wraps past 0xFFFF_FFFC; ROM aliases to index 127
    vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 32'h00000013, 32'h0,        32'h0,        13, 1));
    vecs.push_back(mk(0, 0, 32'h0,        32'h00,       1, 32'h1000007F, 32'hFFFFFFFC, 32'h00,       14, 1));
    vecs.push_back(mk(1, 0, 32'h0,        32'h00,       1, 32'h1000007F, 32'hFFFFFFFC, 32'h00,       14, 1));

    // Reset and check reset state
    rst_n = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_target_i = '0;
    repeat (2) @(posedge clk);
    #1;
    e = '{addr: 32'h0, valid: 1'b0, instr: 32'h13, pc: 32'h0, pc4: 32'h0, cnt: 32'h0, err: 1'b0};
    chk_all("reset", e);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table through the scoreboard. The boot edge already captured
    // address 0, so the first table entry describes that edge.
    sb.push_back(vecs[0].exp);
    for (int unsigned n = 0; n < vecs.size(); n++) begin
      if (n != 0) begin
        stall_i           = vecs[n].stall;
        redirect_i        = vecs[n].redir;
        redirect_target_i = vecs[n].target;
        sb.push_back(vecs[n].exp);
        @(posedge clk);
        #1;
      end
      if (sb.size() == 0) begin
        total++;
        $display("FAIL scoreboard: got empty queue expected entry at vector %0d", n);
      end else begin
        e = sb.pop_front();
        chk_all($sformatf("vec%0d", n), e);
      end
    end

    // Asynchronous reset in the middle of a stalled cycle
    stall_i    = 1'b1;
    redirect_i = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    e = '{addr: 32'h0, valid: 1'b0, instr: 32'h13, pc: 32'h0, pc4: 32'h0, cnt: 32'h0, err: 1'b0};
    chk_all("async_rst", e);
    @(posedge clk);
    #1;
    chk_all("rst_hold", e);
    @(negedge clk);
    rst_n   = 1'b1;
    stall_i = 1'b0;
    @(posedge clk);
    #1;
    e = '{addr: 32'h4, valid: 1'b1, instr: 32'h493, pc: 32'h0, pc4: 32'h4, cnt: 32'h1, err: 1'b0};
    chk_all("restart0", e);
    @(posedge clk);
    #1;
    e = '{addr: 32'h8, valid: 1'b1, instr: 32'h413, pc: 32'h4, pc4: 32'h8, cnt: 32'h2, err: 1'b0};
    chk_all("restart1", e);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
